// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/step controller for the single-cycle MIPS core.
// Issues one-cycle clock-enable pulses to the core on a prescaled tick and
// supports free-run, single-step, halt, breakpoint and core restart, driven
// from board switches and active-low push keys.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   sw[1:0]   sw[0]=1 free-run, 0 step; sw[1]=1 breakpoint enable
//   key[1:0]  raw active-low keys; key[0] run/halt/step, key[1] core restart
//   pc        current PC of the core
//   cpu_en    one-cycle enable pulse, core advances one instruction per pulse
//   cpu_rst   active-high core reset
//   state     00 RESET, 01 HALT, 10 RUN, 11 STEP
//   halted    1 while in HALT
//   step_cnt  enables issued since last core restart, saturating
//
// Build option: define RUN_CTRL_BP_EN to build the breakpoint comparator
// and the bp_skip flag; without it sw[1] and pc are ignored.
module mips_run_ctrl #(
  parameter int unsigned DIV     = 10,
  parameter logic [19:0] DEB_CNT = 20'd500000,
  parameter int unsigned RST_CYC = 4,
  parameter logic [31:0] BP_ADDR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sw,
  input  logic [1:0]  key,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] step_cnt
);

  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYC - 1);

  localparam logic [1:0] S_RESET = 2'b00;
  localparam logic [1:0] S_HALT  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_STEP  = 2'b11;

  // Key synchroniser, debounce and press detection
  logic [1:0]  key_m;
  logic [1:0]  key_s;
  logic [1:0]  key_lvl;
  logic [1:0]  press;
  logic [19:0] deb_cnt [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      key_m      <= 2'b11;
      key_s      <= 2'b11;
      key_lvl    <= 2'b11;
      press      <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      key_m <= key;
      key_s <= key_m;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        // counter runs only while the synchronised level differs from the accepted one
        if (key_s[i] == key_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_CNT - 20'd1) begin
          deb_cnt[i] <= '0;
          key_lvl[i] <= key_s[i];
          press[i]   <= ~key_s[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Free-running prescaler
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_c;

  assign tick_c = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Breakpoint match
  logic bp_hit_c;
`ifdef RUN_CTRL_BP_EN
  logic bp_skip;
  logic bp_skip_nxt;

  // bp_skip lets the first tick after a resume step off the breakpoint PC
  assign bp_hit_c = sw[1] && (pc == BP_ADDR) && !bp_skip;
`else
  logic unused_bp;

  assign unused_bp = ^{pc ^ BP_ADDR, sw[1]};
  assign bp_hit_c  = 1'b0;
`endif

  // Next-state and output decode
  logic [1:0]        state_nxt;
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_nxt;
  logic              en_nxt;
  logic              rst_nxt;

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    en_nxt    = 1'b0;
    rst_nxt   = 1'b0;
`ifdef RUN_CTRL_BP_EN
    bp_skip_nxt = bp_skip;
`endif
    if (press[1]) begin
      // restart wins over every other event
      state_nxt = S_RESET;
      rcnt_nxt  = '0;
      rst_nxt   = 1'b1;
    end else begin
      case (state)
        S_RESET: begin
          rst_nxt = 1'b1;
          if (rcnt == RCNT_LAST) begin
            state_nxt = S_HALT;
            rst_nxt   = 1'b0;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + RCNT_W'(1);
          end
        end
        S_HALT: begin
          if (press[0]) begin
            state_nxt = sw[0] ? S_RUN : S_STEP;
`ifdef RUN_CTRL_BP_EN
            bp_skip_nxt = 1'b1;
`endif
          end
        end
        S_STEP: begin
          if (tick_c) begin
            en_nxt    = 1'b1;
            state_nxt = S_HALT;
          end
        end
        S_RUN: begin
          // halt request suppresses a same-cycle tick
          if (press[0] || !sw[0]) begin
            state_nxt = S_HALT;
          end else if (tick_c) begin
            if (bp_hit_c) begin
              state_nxt = S_HALT;
            end else begin
              en_nxt = 1'b1;
`ifdef RUN_CTRL_BP_EN
              bp_skip_nxt = 1'b0;
`endif
            end
          end
        end
        default: state_nxt = S_RESET;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      rcnt     <= '0;
      cpu_en   <= 1'b0;
      cpu_rst  <= 1'b1;
      halted   <= 1'b0;
      step_cnt <= '0;
`ifdef RUN_CTRL_BP_EN
      bp_skip  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rcnt    <= rcnt_nxt;
      cpu_en  <= en_nxt;
      cpu_rst <= rst_nxt;
      halted  <= (state_nxt == S_HALT);
`ifdef RUN_CTRL_BP_EN
      bp_skip <= bp_skip_nxt;
`endif
      if (state == S_RESET || state_nxt == S_RESET) begin
        step_cnt <= '0;
      end else if (en_nxt && step_cnt != 16'hFFFF) begin
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: self-checking bench for mips_run_ctrl with DIV=4,
// DEB_CNT=3, RST_CYC=4. A behavioural model built from the controller's
// rules predicts every output each cycle; directed checks cover reset,
// step, glitch, run/halt, restart, breakpoint and saturation.
module tb_mips_run_ctrl;

  localparam int unsigned DIV     = 4;
  localparam int unsigned DEB     = 3;
  localparam int unsigned RST_CYC = 4;
  localparam logic [31:0] BP_ADDR = 32'h0000_0040;
  localparam int unsigned CYC_LIMIT = 60000;

  localparam int unsigned M_RESET = 0;
  localparam int unsigned M_HALT  = 1;
  localparam int unsigned M_RUN   = 2;
  localparam int unsigned M_STEP  = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  sw;
  logic [1:0]  key;
  logic [31:0] pc;
  logic        cpu_en;
  logic        cpu_rst;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] step_cnt;

  int unsigned n_total;
  int unsigned n_bad;
  bit          chk_on;
  bit          preload;

  mips_run_ctrl #(
    .DIV     (DIV),
    .DEB_CNT (20'(DEB)),
    .RST_CYC (RST_CYC),
    .BP_ADDR (BP_ADDR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .key      (key),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .cpu_rst  (cpu_rst),
    .state    (state),
    .halted   (halted),
    .step_cnt (step_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: prescaler phase from edge count, debounce as a window of
  // recent synchronised samples, controller as a mode plus remaining-reset count.
  int unsigned     m_phase;
  logic [1:0]      m_k1;
  logic [1:0]      m_k2;
  logic [DEB-1:0]  m_win [2];
  logic [1:0]      m_acc;
  logic [1:0]      m_press;
  int unsigned     m_mode;
  int              m_left;
  int unsigned     m_cnt;
  bit              m_skip;
  bit              m_en;

  initial forever begin
    bit       tick;
    bit       hit;
    logic [1:0] press_now;
    @(posedge clk);
    if (rst) begin
      m_phase  = 0;
      m_k1     = 2'b11;
      m_k2     = 2'b11;
      m_win[0] = '1;
      m_win[1] = '1;
      m_acc    = 2'b11;
      m_press  = 2'b00;
      m_mode   = M_RESET;
      m_left   = RST_CYC;
      m_cnt    = 0;
      m_skip   = 1'b0;
      m_en     = 1'b0;
    end else begin
      tick = ((m_phase % DIV) == DIV - 1);
      m_phase++;
      press_now = m_press;
      m_press = 2'b00;
      for (int i = 0; i < 2; i++) begin
        m_win[i] = {m_win[i][DEB-2:0], m_k2[i]};
        if (m_win[i] == '1 && !m_acc[i]) begin
          m_acc[i] = 1'b1;
        end else if (m_win[i] == '0 && m_acc[i]) begin
          m_acc[i]   = 1'b0;
          m_press[i] = 1'b1;
        end
      end
      m_k2 = m_k1;
      m_k1 = key;
`ifdef RUN_CTRL_BP_EN
      hit = sw[1] && (pc == BP_ADDR) && !m_skip;
`else
      hit = 1'b0;
`endif
      m_en = 1'b0;
      if (press_now[1]) begin
        m_mode = M_RESET;
        m_left = RST_CYC;
        m_cnt  = 0;
      end else begin
        case (m_mode)
          M_RESET: begin
            m_cnt = 0;
            m_left--;
            if (m_left == 0) m_mode = M_HALT;
          end
          M_HALT: if (press_now[0]) begin
            m_mode = sw[0] ? M_RUN : M_STEP;
            m_skip = 1'b1;
          end
          M_STEP: if (tick) begin
            m_en   = 1'b1;
            m_mode = M_HALT;
          end
          default: begin
            if (press_now[0] || !sw[0]) begin
              m_mode = M_HALT;
            end else if (tick) begin
              if (hit) begin
                m_mode = M_HALT;
              end else begin
                m_en   = 1'b1;
                m_skip = 1'b0;
              end
            end
          end
        endcase
      end
      if (preload) m_cnt = 32'h0000_FFF0;
      if (m_en && m_cnt < 32'h0000_FFFF) m_cnt++;
    end
  end

  // Per-cycle comparison against the model, plus a simple core PC model
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check_eq("cpu_en",   32'(cpu_en),   32'(m_en));
      check_eq("cpu_rst",  32'(cpu_rst),  32'(m_mode == M_RESET));
      check_eq("state",    32'(state),    m_mode);
      check_eq("halted",   32'(halted),   32'(m_mode == M_HALT));
      check_eq("step_cnt", 32'(step_cnt), m_cnt);
    end
    if (cpu_rst) pc = 32'd0;
    else if (cpu_en) pc = pc + 32'd4;
  end

  initial begin
    #(CYC_LIMIT * 10);
    $display("FAIL timeout got=%0d exp=<%0d cycles", CYC_LIMIT, CYC_LIMIT);
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int idx, input int hold);
    key[idx] = 1'b0;
    idle(hold);
    key[idx] = 1'b1;
    idle(DEB + 4);
  endtask

  initial begin
    int n;
    int c;
    bit seen;
    n_total = 0;
    n_bad   = 0;
    chk_on  = 1'b0;
    preload = 1'b0;
    rst     = 1'b1;
    sw      = 2'b00;
    key     = 2'b11;
    idle(2);
    chk_on = 1'b1;
    rst    = 1'b0;

    // reset values, then 4 cycles of core reset
    check_eq("rst_state",  32'(state),    32'd0);
    check_eq("rst_cpurst", 32'(cpu_rst),  32'd1);
    check_eq("rst_en",     32'(cpu_en),   32'd0);
    check_eq("rst_cnt",    32'(step_cnt), 32'd0);
    check_eq("rst_halted", 32'(halted),   32'd0);
    idle(3);
    check_eq("rst_hold",   32'(cpu_rst),  32'd1);
    idle(1);
    check_eq("rst_done",   32'(state),    32'd1);
    check_eq("rst_halt",   32'(halted),   32'd1);
    check_eq("rst_rel",    32'(cpu_rst),  32'd0);

    // single step, then a short glitch that must be rejected
    sw = 2'b00;
    push(0, 5);
    idle(10);
    check_eq("step_cnt1", 32'(step_cnt), 32'd1);
    check_eq("step_halt", 32'(state),    32'd1);
    key[0] = 1'b0;
    idle(2);
    key[0] = 1'b1;
    idle(12);
    check_eq("glitch",    32'(step_cnt), 32'd1);

    // free run for 10 pulses, then halt by key
    sw = 2'b01;
    push(0, 4);
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (cpu_en) n++;
    end
    check_eq("run_pulses", 32'(n), 32'd10);
    push(0, 4);
    idle(6);
    check_eq("run_halt", 32'(state), 32'd1);

    // leaving free-run mode halts
    push(0, 4);
    idle(9);
    check_eq("run_again", 32'(state), 32'd2);
    sw = 2'b00;
    idle(2);
    check_eq("sw_halt", 32'(state), 32'd1);

    // restart from RUN
    sw = 2'b01;
    push(0, 4);
    idle(8);
    key[1] = 1'b0;
    idle(4);
    key[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cpu_rst) seen = 1'b1;
    end
    check_eq("restart_seen", 32'(seen), 32'd1);
    c = 0;
    while (cpu_rst && c < 20) begin
      c++;
      @(negedge clk);
    end
    check_eq("restart_len",  32'(c),        32'd4);
    check_eq("restart_st",   32'(state),    32'd1);
    check_eq("restart_cnt",  32'(step_cnt), 32'd0);
    idle(4);

    // breakpoint at 0x40
    sw = 2'b11;
    push(0, 4);
    idle(100);
`ifdef RUN_CTRL_BP_EN
    check_eq("bp_halt", 32'(state), 32'd1);
    check_eq("bp_pc",   pc,         BP_ADDR);
    push(0, 4);
    idle(8);
    check_eq("bp_resume", 32'(state),       32'd2);
    check_eq("bp_leave",  32'(pc > BP_ADDR), 32'd1);
`else
    check_eq("bp_off",  32'(state),        32'd2);
    check_eq("bp_past", 32'(pc > BP_ADDR), 32'd1);
`endif
    push(0, 4);
    idle(4);
    check_eq("bp_stop", 32'(state), 32'd1);

    // saturation: preload the counter close to the top, then run past it
    sw = 2'b01;
    idle(2);
    #1;
    force dut.step_cnt = 16'hFFF0;
    preload = 1'b1;
    @(negedge clk);
    #1;
    release dut.step_cnt;
    preload = 1'b0;
    push(0, 4);
    idle(80);
    check_eq("sat", 32'(step_cnt), 32'h0000_FFFF);

    // synchronous reset mid-run with a restart key still being debounced
    key[1] = 1'b0;
    idle(3);
    rst = 1'b1;
    key[1] = 1'b1;
    idle(1);
    rst = 1'b0;
    check_eq("mrst_en",     32'(cpu_en),   32'd0);
    check_eq("mrst_cpurst", 32'(cpu_rst),  32'd1);
    check_eq("mrst_state",  32'(state),    32'd0);
    check_eq("mrst_halted", 32'(halted),   32'd0);
    check_eq("mrst_cnt",    32'(step_cnt), 32'd0);
    idle(12);
    check_eq("mrst_halt",   32'(state),    32'd1);

    // randomised key/switch activity
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 6) begin
        push(0, int'($urandom_range(3, 6)));
      end else if (r < 8) begin
        key[0] = 1'b0;
        idle(int'($urandom_range(1, 2)));
        key[0] = 1'b1;
        idle(int'($urandom_range(1, 8)));
      end else if (r < 10) begin
        // bouncy press
        for (int b = 0; b < int'($urandom_range(2, 6)); b++) begin
          key[0] = 1'($urandom);
          idle(1);
        end
        key[0] = 1'b0;
        idle(5);
        key[0] = 1'b1;
        idle(DEB + 4);
      end else if (r == 10) begin
        sw = 2'($urandom);
      end else if (r == 11) begin
        sw[0] = ~sw[0];
      end else if (r == 12) begin
        push(1, int'($urandom_range(3, 5)));
      end else if (r == 13 && ($urandom_range(0, 3) == 0)) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end else begin
        idle(int'($urandom_range(1, 12)));
      end
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
